// File: rtl/branch_target_cache.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_cache
// Brief    : Direct-mapped fetch-stage branch target cache with flush sweep.
//            Optional macro BTB_2BIT_CTR_EN selects 2-bit saturating counters.
// Revision : 1.0 - initial release
// ============================================================================

package branch_target_cache_pkg;
   typedef struct packed {
      logic        v;
      logic [5:0]  tag;
      logic        t;
      logic [31:0] ta;
   } CACHE_BRANCH;
endpackage

module branch_target_cache
   import branch_target_cache_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC,
   output logic [5:0]  TAG_PC,
   output CACHE_BRANCH data_out_CACHE,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush,
   output logic        busy
);

   localparam int c_DEPTH = 1 << IDX_W;
`ifdef BTB_2BIT_CTR_EN
   localparam int c_CTR_W = 2;
`else
   localparam int c_CTR_W = 1;
`endif
   // Allocation state is "weakly taken": MSB set, all lower bits clear.
   localparam logic [c_CTR_W-1:0] c_CTR_INIT = {1'b1, {(c_CTR_W-1){1'b0}}};
   localparam logic [c_CTR_W-1:0] c_CTR_MAX  = '1;
   localparam logic [IDX_W-1:0]   c_CNT_LAST = '1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_cnt;

   logic               r_v   [c_DEPTH];
   logic [5:0]         r_tag [c_DEPTH];
   logic [c_CTR_W-1:0] r_ctr [c_DEPTH];
   logic [31:0]        r_ta  [c_DEPTH];

   logic [IDX_W-1:0]   w_lidx;
   logic [IDX_W-1:0]   w_uidx;
   logic [5:0]         w_utag;
   logic               w_hit;
   logic               w_upd_ok;
   logic [c_CTR_W-1:0] w_ctr_cur;
   logic [c_CTR_W-1:0] w_ctr_inc;
   logic [c_CTR_W-1:0] w_ctr_dec;
   logic               w_unused_addr;

   assign w_lidx = PC[IDX_W+1:2];
   assign TAG_PC = PC[IDX_W+7:IDX_W+2];
   assign w_uidx = upd_pc[IDX_W+1:2];
   assign w_utag = upd_pc[IDX_W+7:IDX_W+2];
   assign w_unused_addr = ^{PC[31:IDX_W+8], PC[1:0], upd_pc[31:IDX_W+8], upd_pc[1:0]};

   assign busy      = (r_state == ST_SWEEP);
   assign w_hit     = r_v[w_uidx] && (r_tag[w_uidx] == w_utag);
   // A flush in the same idle cycle takes priority over the update.
   assign w_upd_ok  = upd_en && (r_state == ST_IDLE) && !flush;
   assign w_ctr_cur = r_ctr[w_uidx];
   assign w_ctr_inc = (w_ctr_cur == c_CTR_MAX) ? w_ctr_cur : w_ctr_cur + 1'b1;
   assign w_ctr_dec = (w_ctr_cur == '0)        ? w_ctr_cur : w_ctr_cur - 1'b1;

   always_comb begin
      data_out_CACHE = '0;
      if (!busy) begin
         data_out_CACHE.v   = r_v[w_lidx];
         data_out_CACHE.tag = r_tag[w_lidx];
         data_out_CACHE.t   = r_ctr[w_lidx][c_CTR_W-1];
         data_out_CACHE.ta  = r_ta[w_lidx];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (flush) w_state_nxt = ST_SWEEP;
         ST_SWEEP: if (r_cnt == c_CNT_LAST) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < c_DEPTH; i++) begin
            r_v[i]   <= 1'b0;
            r_tag[i] <= '0;
            r_ctr[i] <= '0;
            r_ta[i]  <= '0;
         end
      end else begin
         if (r_state == ST_SWEEP) begin
            r_v[r_cnt] <= 1'b0;
            r_cnt      <= r_cnt + 1'b1;
         end else if (flush) begin
            r_cnt <= '0;
         end

         if (w_upd_ok) begin
            if (upd_taken) begin
               r_ta[w_uidx] <= upd_target;
               if (w_hit) begin
                  r_ctr[w_uidx] <= w_ctr_inc;
               end else begin
                  r_v[w_uidx]   <= 1'b1;
                  r_tag[w_uidx] <= w_utag;
                  r_ctr[w_uidx] <= c_CTR_INIT;
               end
            end else if (w_hit) begin
               r_ctr[w_uidx] <= w_ctr_dec;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_cache.sv
`default_nettype none
// Testbench for branch_target_cache: cycle-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_branch_target_cache;
   import branch_target_cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PC;
   logic [5:0]  TAG_PC;
   CACHE_BRANCH data_out_CACHE;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   branch_target_cache #(.IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .PC(PC), .TAG_PC(TAG_PC),
      .data_out_CACHE(data_out_CACHE), .upd_en(upd_en), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target), .flush(flush), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
`ifdef BTB_2BIT_CTR_EN
   localparam int M_MAX = 3, M_INIT = 2, M_TBIT = 2;
`else
   localparam int M_MAX = 1, M_INIT = 1, M_TBIT = 1;
`endif
   bit        m_v   [16];
   bit [5:0]  m_tag [16];
   bit [31:0] m_ta  [16];
   int        m_ctr [16];
   int        m_left = 0;   // remaining sweep cycles

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
               m_v[i] = 0; m_tag[i] = 0; m_ta[i] = 0; m_ctr[i] = 0;
            end
            m_left = 0;
         end else if (m_left > 0) begin
            m_v[16 - m_left] = 0;
            m_left--;
         end else if (flush) begin
            m_left = 16;
         end else if (upd_en) begin
            int  ix;
            bit  hit;
            ix  = (upd_pc >> 2) % 16;
            hit = m_v[ix] && (m_tag[ix] == ((upd_pc >> 6) % 64));
            if (upd_taken && !hit) begin
               m_v[ix] = 1; m_tag[ix] = 6'((upd_pc >> 6) % 64);
               m_ta[ix] = upd_target; m_ctr[ix] = M_INIT;
            end else if (upd_taken) begin
               m_ta[ix] = upd_target;
               if (m_ctr[ix] < M_MAX) m_ctr[ix]++;
            end else if (hit) begin
               if (m_ctr[ix] > 0) m_ctr[ix]--;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         logic [39:0] exp;
         int ix;
         @(negedge clk);
         ix = (PC >> 2) % 16;
         if (m_left > 0) exp = '0;
         else exp = {m_v[ix], m_tag[ix], 1'(m_ctr[ix] >= M_TBIT), m_ta[ix]};
         chk("model_entry", 64'(data_out_CACHE), 64'(exp));
         chk("model_busy", 64'(busy), 64'(m_left > 0));
         chk("model_tag_pc", 64'(TAG_PC), 64'((PC >> 6) % 64));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic set_upd(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tg;
   endtask

   task automatic upd_one(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      set_upd(1'b1, pc, tk, tg);
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  nb;
      bit  done;
      rst_n = 1'b0; PC = '0; flush = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         PC = 32'(i * 4);
         @(negedge clk);
         chk("rst_v", 64'(data_out_CACHE.v), 64'd0);
         chk("rst_ta", 64'(data_out_CACHE.ta), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         cyc();
      end

      // allocate at 0x104: index 1, tag 4
      set_upd(1'b1, 32'h104, 1'b1, 32'h200);
      PC = 32'h104;
      @(negedge clk);
      chk("same_cycle_v", 64'(data_out_CACHE.v), 64'd0);
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk("alloc_v", 64'(data_out_CACHE.v), 64'd1);
      chk("alloc_tag", 64'(data_out_CACHE.tag), 64'h04);
      chk("alloc_tag_pc", 64'(TAG_PC), 64'h04);
      chk("alloc_t", 64'(data_out_CACHE.t), 64'd1);
      chk("alloc_ta", 64'(data_out_CACHE.ta), 64'h200);

      // same index, different tag (5)
      PC = 32'h144;
      @(negedge clk);
      chk("alias_v", 64'(data_out_CACHE.v), 64'd1);
      chk("alias_tag", 64'(data_out_CACHE.tag), 64'h04);
      chk("alias_tag_pc", 64'(TAG_PC), 64'h05);
      upd_one(32'h144, 1'b1, 32'h300);
      @(negedge clk);
      chk("evict_tag", 64'(data_out_CACHE.tag), 64'h05);
      chk("evict_ta", 64'(data_out_CACHE.ta), 64'h300);

      // prediction hysteresis
      upd_one(32'h144, 1'b0, 32'h0);
      @(negedge clk);
      chk("nt1_t", 64'(data_out_CACHE.t), 64'd0);
      chk("nt1_v", 64'(data_out_CACHE.v), 64'd1);
      upd_one(32'h144, 1'b1, 32'h300);
      @(negedge clk);
      chk("tk_t", 64'(data_out_CACHE.t), 64'd1);
      upd_one(32'h144, 1'b0, 32'h0);
      upd_one(32'h144, 1'b0, 32'h0);
      upd_one(32'h144, 1'b1, 32'h300);
      @(negedge clk);
`ifdef BTB_2BIT_CTR_EN
      chk("nt2_tk_t", 64'(data_out_CACHE.t), 64'd0);
`else
      chk("nt2_tk_t", 64'(data_out_CACHE.t), 64'd1);
`endif
      upd_one(32'h184, 1'b0, 32'h999);
      @(negedge clk);
      chk("ntmiss_tag", 64'(data_out_CACHE.tag), 64'h05);

      // fill, flush, update 3 cycles later (dropped), flush mid-sweep ignored
      for (int i = 0; i < 16; i++) upd_one(32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i));
      flush = 1'b1; PC = 32'h1000;
      cyc();
      flush = 1'b0;
      nb = 0; done = 0;
      for (int j = 0; j < 40 && !done; j++) begin
         if (j == 2)       set_upd(1'b1, 32'h1000, 1'b1, 32'hBEEF);
         else if (j == 16) set_upd(1'b1, 32'h1008, 1'b1, 32'h5555);
         else              set_upd(1'b0, 32'h0, 1'b0, 32'h0);
         flush = (j == 5);
         PC = 32'h1000 + 32'((j % 16) * 4);
         @(negedge clk);
         if (busy) begin
            nb++;
            chk("sweep_v", 64'(data_out_CACHE.v), 64'd0);
         end else begin
            done = 1;
         end
         cyc();
      end
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      flush = 1'b0;
      chk("busy_len", 64'(nb), 64'd16);
      for (int i = 0; i < 16; i++) begin
         PC = 32'h1000 + 32'(i * 4);
         @(negedge clk);
         chk("post_flush_v", 64'(data_out_CACHE.v), 64'(i == 2));
         if (i == 2) chk("post_flush_ta", 64'(data_out_CACHE.ta), 64'h5555);
         cyc();
      end

      // reset in sweep cycle 5
      for (int i = 0; i < 16; i++) upd_one(32'h1000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i));
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      repeat (5) cyc();
      PC = 32'h1030;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_v", 64'(data_out_CACHE.v), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         PC = 32'h1000 + 32'(i * 4);
         @(negedge clk);
         chk("rst_mid_clear", 64'(data_out_CACHE.v), 64'd0);
         cyc();
      end
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      nb = 0; done = 0;
      for (int j = 0; j < 40 && !done; j++) begin
         @(negedge clk);
         if (busy) nb++;
         else done = 1;
         cyc();
      end
      chk("busy_len_after_rst", 64'(nb), 64'd16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
